instr_word_encoder: RTL
=======================

Name: instr_word_encoder

Overview:
- Encoder counterpart to the core's instruction decoder: accepts field-level instruction requests and assembles the 32-bit ARM word the controller decodes.
- Writes each encoded word sequentially into instruction memory during program load, ahead of core release.
- Covers data-processing (register and rotated-immediate operand), LDR/STR with immediate offset, B/BL and BX.
- Reports unencodable requests on a one-cycle error strobe.

Parameters:
- ADDR_W, 8, width of the instruction-memory byte address and of word_count.
- DEPTH, 64, maximum number of words written; DEPTH*4 <= 2^ADDR_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous active-low reset.
- prog_clear  in  1  synchronous clear: aborts the current operation with no write, zeroes address and count, returns to IDLE; wins over all other inputs.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; accept = req_valid & req_ready at a rising edge.
- req_class  in  2  00 DP, 01 MEM, 10 BRANCH, 11 BX.
- req_cond  in  4  condition field, copied to word[31:28].
- req_cmd  in  4  DP cmd: 0000 AND, 0010 SUB, 0100 ADD, 1100 ORR, 1101 MOV, 1010 CMP.
- req_s  in  1  DP S bit.
- req_imm  in  1  DP: operand2 is immediate.
- req_load  in  1  MEM: 1 LDR, 0 STR.
- req_link  in  1  BRANCH: 1 BL.
- req_rn, req_rd, req_rm  in  4 each  register fields.
- req_value  in  32  DP immediate (unrotated), MEM offset (unsigned), or BRANCH word offset (signed).
- im_we  out  1  instruction-memory write strobe.
- im_addr  out  ADDR_W  byte address of the current write.
- im_wdata  out  32  encoded word.
- err_valid  out  1  one-cycle error strobe.
- err_code  out  2  00 FULL, 01 IMM, 10 OFFS, 11 BRANCH; held until the next error.
- word_count  out  ADDR_W  number of words written.

Behaviour:
- Reset: state IDLE; im_we=0, im_addr=0, im_wdata=0, err_valid=0, err_code=00, word_count=0. req_ready=1 after reset.
- States: IDLE, SEARCH, WRITE, ERROR. Request fields are latched at accept.
- Accept checks, in priority order:
  - word_count==DEPTH -> ERROR with FULL.
  - MEM with req_value>4095 -> ERROR with OFFS.
  - BRANCH with req_value[31:23] not all equal -> ERROR with BRANCH.
  - DP with req_imm=1 -> SEARCH with rot=0.
  - Otherwise -> WRITE with the word formed.
- SEARCH runs one rotation per cycle:
  - Match when ROL(value, 2*rot)[31:8]==0; imm12 = {rot[3:0], ROL(value, 2*rot)[7:0]}; go to WRITE.
  - No match at rot=15 -> ERROR with IMM.
  - Lowest matching rot wins. SEARCH lasts r+1 cycles for match at rot r, 16 cycles on failure.
- WRITE lasts one cycle:
  - im_we=1 with im_wdata and im_addr stable.
  - On exit: im_addr += 4, word_count += 1, go to IDLE.
  - Latency without search: im_we high in the cycle immediately after the accept edge.
- ERROR lasts one cycle: err_valid=1, err_code updated, no write, address unchanged, go to IDLE.
- Encodings:
  - DP: {cond, 00, I, cmd, S, Rn, Rd, op2}; op2 = {8'h00, Rm} or imm12. CMP forces S=1 and Rd=0. MOV forces Rn=0.
  - MEM: {cond, 01, 0, 1, 1, 0, 0, L, Rn, Rd, value[11:0]} (offset, pre-index, up, word, no writeback).
  - BRANCH: {cond, 101, link, value[23:0]}.
  - BX: {cond, 24'h12FFF1, Rm}.
- RESET low in any state: immediate return to reset values, with no partial write.

Test Plan:
- ADD R1,R2,R3, cond 1110, register operand -> im_we one cycle after accept, im_wdata=0xE0821003, im_addr=0x00, word_count=1.
- MOV R0,#0xFF000000 -> five SEARCH cycles (rot 0..4), then im_wdata=0xE3A004FF at im_addr=0x04.
- DP immediate 0x00000101 -> 16 SEARCH cycles, then err_valid for one cycle with err_code=01, no im_we, im_addr unchanged.
- Further encodings:
  - LDR R4,[R5,#8] -> 0xE5954008.
  - B, cond 0000, offset 0xFFFFFFFE -> 0x0AFFFFFE.
  - BL, cond 1110, offset 0x10 -> 0xEB000010.
  - BX R14, cond 1110 -> 0xE12FFF1E.
  - MEM offset 4096 -> err_code=10.
- DEPTH=4: four valid writes, then a fifth request -> err_code=00, no im_we, word_count stays 4. After prog_clear, the next write goes to im_addr=0x00.
- Assert RESET low during SEARCH at rot=3 -> no im_we; outputs return to reset values; req_ready=1 after RESET releases.

Source files
------------

// File: rtl/instr_word_encoder.sv
// Field-level instruction encoder: assembles 32-bit ARM words and writes them
// sequentially into instruction memory, searching rotations for DP immediates.
module instr_word_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              prog_clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_class,
    input  logic [3:0]        req_cond,
    input  logic [3:0]        req_cmd,
    input  logic              req_s,
    input  logic              req_imm,
    input  logic              req_load,
    input  logic              req_link,
    input  logic [3:0]        req_rn,
    input  logic [3:0]        req_rd,
    input  logic [3:0]        req_rm,
    input  logic [31:0]       req_value,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] word_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_WRITE  = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    localparam logic [1:0] CLS_DP     = 2'b00;
    localparam logic [1:0] CLS_MEM    = 2'b01;
    localparam logic [1:0] CLS_BRANCH = 2'b10;

    localparam logic [1:0] ERR_FULL   = 2'b00;
    localparam logic [1:0] ERR_IMM    = 2'b01;
    localparam logic [1:0] ERR_OFFS   = 2'b10;
    localparam logic [1:0] ERR_BRANCH = 2'b11;

    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    state_t              state_q;
    logic [3:0]          rot_q;
    logic [3:0]          cond_q;
    logic [3:0]          cmd_q;
    logic                s_q;
    logic [3:0]          rn_q;
    logic [3:0]          rd_q;
    logic [31:0]         value_q;
    logic                im_we_q;
    logic [ADDR_W-1:0]   im_addr_q;
    logic [31:0]         im_wdata_q;
    logic                err_valid_q;
    logic [1:0]          err_code_q;
    logic [ADDR_W-1:0]   count_q;

    logic [31:0]         rol_d;
    logic [31:0]         direct_word_d;
    logic [31:0]         search_word_d;
    logic                full_d;
    logic                branch_range_ok_d;

    function automatic logic [31:0] rol32(input logic [31:0] v, input logic [3:0] rot);
        logic [63:0] dbl;
        dbl = {v, v} << {rot, 1'b0};
        return dbl[63:32];
    endfunction

    function automatic logic [31:0] encode(
        input logic [1:0]  cls,
        input logic [3:0]  cond,
        input logic [3:0]  cmd,
        input logic        s,
        input logic        imm,
        input logic        load,
        input logic        link,
        input logic [3:0]  rn,
        input logic [3:0]  rd,
        input logic [3:0]  rm,
        input logic [31:0] value,
        input logic [11:0] imm12
    );
        logic [31:0] word;
        logic [11:0] op2;
        logic        s_f;
        logic [3:0]  rn_f;
        logic [3:0]  rd_f;
        op2  = imm ? imm12 : {8'h00, rm};
        s_f  = s | (cmd == CMD_CMP);
        rd_f = (cmd == CMD_CMP) ? 4'h0 : rd;
        rn_f = (cmd == CMD_MOV) ? 4'h0 : rn;
        case (cls)
            CLS_DP:     word = {cond, 2'b00, imm, cmd, s_f, rn_f, rd_f, op2};
            CLS_MEM:    word = {cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, load, rn, rd, value[11:0]};
            CLS_BRANCH: word = {cond, 3'b101, link, value[23:0]};
            default:    word = {cond, 24'h12FFF1, rm};
        endcase
        return word;
    endfunction

    assign rol_d             = rol32(value_q, rot_q);
    assign full_d            = (count_q == ADDR_W'(DEPTH));
    // Offset must sign-extend from bit 23 to fit the 24-bit branch field.
    assign branch_range_ok_d = (req_value[31:23] == 9'h000) || (req_value[31:23] == 9'h1FF);
    assign direct_word_d     = encode(req_class, req_cond, req_cmd, req_s, req_imm, req_load,
                                      req_link, req_rn, req_rd, req_rm, req_value, 12'h000);
    assign search_word_d     = encode(CLS_DP, cond_q, cmd_q, s_q, 1'b1, 1'b0, 1'b0,
                                      rn_q, rd_q, 4'h0, value_q, {rot_q, rol_d[7:0]});

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            rot_q       <= 4'h0;
            cond_q      <= 4'h0;
            cmd_q       <= 4'h0;
            s_q         <= 1'b0;
            rn_q        <= 4'h0;
            rd_q        <= 4'h0;
            value_q     <= 32'h0;
            im_we_q     <= 1'b0;
            im_addr_q   <= '0;
            im_wdata_q  <= 32'h0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_FULL;
            count_q     <= '0;
        end else if (prog_clear) begin
            state_q     <= S_IDLE;
            im_we_q     <= 1'b0;
            err_valid_q <= 1'b0;
            im_addr_q   <= '0;
            count_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        cond_q  <= req_cond;
                        cmd_q   <= req_cmd;
                        s_q     <= req_s;
                        rn_q    <= req_rn;
                        rd_q    <= req_rd;
                        value_q <= req_value;
                        rot_q   <= 4'h0;
                        if (full_d) begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_FULL;
                            state_q     <= S_ERROR;
                        end else if (req_class == CLS_MEM && req_value > 32'd4095) begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_OFFS;
                            state_q     <= S_ERROR;
                        end else if (req_class == CLS_BRANCH && !branch_range_ok_d) begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_BRANCH;
                            state_q     <= S_ERROR;
                        end else if (req_class == CLS_DP && req_imm) begin
                            state_q <= S_SEARCH;
                        end else begin
                            im_wdata_q <= direct_word_d;
                            im_we_q    <= 1'b1;
                            state_q    <= S_WRITE;
                        end
                    end
                end
                S_SEARCH: begin
                    if (rol_d[31:8] == 24'h0) begin
                        im_wdata_q <= search_word_d;
                        im_we_q    <= 1'b1;
                        state_q    <= S_WRITE;
                    end else if (rot_q == 4'hF) begin
                        err_valid_q <= 1'b1;
                        err_code_q  <= ERR_IMM;
                        state_q     <= S_ERROR;
                    end else begin
                        rot_q <= rot_q + 4'h1;
                    end
                end
                S_WRITE: begin
                    im_we_q   <= 1'b0;
                    im_addr_q <= im_addr_q + ADDR_W'(4);
                    count_q   <= count_q + ADDR_W'(1);
                    state_q   <= S_IDLE;
                end
                default: begin
                    err_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign im_we      = im_we_q;
    assign im_addr    = im_addr_q;
    assign im_wdata   = im_wdata_q;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign word_count = count_q;

endmodule
